// File: rtl/pal_timing_pkg.sv
// Shared PAL timing defaults, coordinate type and window decode helper
// used by the timing generator and its clock-enable divider.
package pal_timing_pkg;

   localparam int COORD_W      = 10;
   localparam int DEF_CE_DIV   = 2;
   localparam int DEF_H_TOTAL  = 864;
   localparam int DEF_H_ACTIVE = 720;
   localparam int DEF_HS_START = 732;
   localparam int DEF_HS_LEN   = 64;
   localparam int DEF_V_TOTAL  = 625;
   localparam int DEF_V_ACTIVE = 576;
   localparam int DEF_VS_START = 581;
   localparam int DEF_VS_LEN   = 5;

   typedef logic [COORD_W-1:0] coord_t;

   // True when v lies in the inclusive window [start, start+len-1].
   function automatic logic in_window(input coord_t v, input int start, input int len);
      return (int'(v) >= start) && (int'(v) <= start + len - 1);
   endfunction

endpackage

// File: rtl/pal_ce_div.sv
// Pixel clock-enable divider: one-clk-wide ce each time the count reaches CE_DIV-1.
module pal_ce_div
   import pal_timing_pkg::*;
#(
   parameter int CE_DIV = DEF_CE_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic ce
);

   localparam int DIV_W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_next;
   logic             ce_next;

   always_comb begin
      div_next = div_reg;
      ce_next  = 1'b0;
      if (clear) begin
         div_next = '0;
      end else if (enable) begin
         div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
         ce_next  = (div_next == DIV_LAST);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_reg <= '0;
         ce      <= 1'b0;
      end else begin
         div_reg <= div_next;
         ce      <= ce_next;
      end
   end

endmodule

// File: rtl/pal_timing_gen.sv
// PAL raster timing generator: pixel/line counters with registered sync and
// active decodes that always line up with the presented coordinates.
module pal_timing_gen
   import pal_timing_pkg::*;
#(
   parameter int CE_DIV   = DEF_CE_DIV,
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_LEN   = DEF_HS_LEN,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int VS_START = DEF_VS_START,
   parameter int VS_LEN   = DEF_VS_LEN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               resync,
   output logic               pixel_ce,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               hsync_n,
   output logic               vsync_n,
   output logic               active
);

   localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);

   coord_t x_reg, x_next;
   coord_t y_reg, y_next;
   logic   pend_reg, pend_next;

   pal_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (resync),
      .ce     (pixel_ce)
   );

   // A pixel_ce swallowed by enable=0 is remembered in pend_reg so the pixel
   // advance happens on the first enabled edge, keeping the sequence gap-free.
   always_comb begin
      x_next    = x_reg;
      y_next    = y_reg;
      pend_next = pend_reg;
      if (resync) begin
         x_next    = '0;
         y_next    = '0;
         pend_next = 1'b0;
      end else if (enable) begin
         pend_next = 1'b0;
         if (pixel_ce || pend_reg) begin
            if (x_reg == X_LAST) begin
               x_next = '0;
               y_next = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
            end else begin
               x_next = x_reg + 1'b1;
            end
         end
      end else begin
         pend_next = pend_reg | pixel_ce;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_reg    <= '0;
         y_reg    <= '0;
         pend_reg <= 1'b0;
         hsync_n  <= 1'b1;
         vsync_n  <= 1'b1;
         active   <= 1'b1;
      end else begin
         x_reg    <= x_next;
         y_reg    <= y_next;
         pend_reg <= pend_next;
         hsync_n  <= ~in_window(x_next, HS_START, HS_LEN);
         vsync_n  <= ~in_window(y_next, VS_START, VS_LEN);
         active   <= (int'(x_next) < H_ACTIVE) && (int'(y_next) < V_ACTIVE);
      end
   end

   assign pixel_x = x_reg;
   assign pixel_y = y_reg;

endmodule

// File: tb/tb_pal_timing_gen.sv
// Self-checking bench for pal_timing_gen on a reduced raster, against a model
// that derives every output from the count of enabled clocks since restart.
module tb_pal_timing_gen;

   localparam int CE_DIV   = 2;
   localparam int H_TOTAL  = 40;
   localparam int H_ACTIVE = 30;
   localparam int HS_START = 32;
   localparam int HS_LEN   = 4;
   localparam int V_TOTAL  = 20;
   localparam int V_ACTIVE = 16;
   localparam int VS_START = 17;
   localparam int VS_LEN   = 2;
   localparam int FRAME_CLK = CE_DIV * H_TOTAL * V_TOTAL;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       resync = 1'b0;
   logic       pixel_ce;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       hsync_n;
   logic       vsync_n;
   logic       active;

   int checks = 0;
   int failures = 0;

   pal_timing_gen #(
      .CE_DIV(CE_DIV), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
      .HS_START(HS_START), .HS_LEN(HS_LEN), .V_TOTAL(V_TOTAL),
      .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_LEN(VS_LEN)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .resync(resync),
      .pixel_ce(pixel_ce), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .hsync_n(hsync_n), .vsync_n(vsync_n), .active(active)
   );

   always #5 clk = ~clk;

   // Reference: n_m = enabled clocks since reset/resync (mod one frame).
   int n_m = 0;
   bit ce_m = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         n_m  <= 0;
         ce_m <= 1'b0;
      end else if (resync) begin
         n_m  <= 0;
         ce_m <= 1'b0;
      end else if (enable) begin
         n_m  <= (n_m + 1) % FRAME_CLK;
         ce_m <= ((n_m + 1) % CE_DIV) == (CE_DIV - 1);
      end else begin
         ce_m <= 1'b0;
      end
   end

   function automatic logic [23:0] model_vec();
      int pix = n_m / CE_DIV;
      int x = pix % H_TOTAL;
      int y = (pix / H_TOTAL) % V_TOTAL;
      logic hs = !(x >= HS_START && x < HS_START + HS_LEN);
      logic vs = !(y >= VS_START && y < VS_START + VS_LEN);
      logic act = (x < H_ACTIVE) && (y < V_ACTIVE);
      return {ce_m, 10'(x), 10'(y), hs, vs, act};
   endfunction

   function automatic logic [23:0] obs_vec();
      return {pixel_ce, pixel_x, pixel_y, hsync_n, vsync_n, active};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pix(input int tx, input int ty, output bit found);
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLK; i++) begin
         tick();
         if (pixel_ce === 1'b1 && pixel_x == tx && pixel_y == ty) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [23:0] rst_vec = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1};
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (obs_vec() !== rst_vec) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", obs_vec(), rst_vec);
      end
      reset = 1'b0;
      enable = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_startup();
      int exp_ce[4] = '{1, 0, 1, 0};
      int exp_x[4]  = '{0, 1, 1, 2};
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (pixel_ce !== exp_ce[i][0] || pixel_x !== 10'(exp_x[i]) || pixel_y !== 10'd0) begin
            failures++;
            $display("FAIL startup_edge%0d got ce=%b x=%0d y=%0d exp ce=%0d x=%0d y=0",
                     i + 1, pixel_ce, pixel_x, pixel_y, exp_ce[i], exp_x[i]);
         end
         checks++;
         if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL startup_model got=%h exp=%h", obs_vec(), model_vec());
         end
      end
      $display("test_startup done");
   endtask

   task automatic test_frame_period();
      bit seen = 1'b0;
      bit done = 1'b0;
      int cnt = 0;
      for (int i = 0; i < 3 * FRAME_CLK && !done; i++) begin
         tick();
         cnt++;
         checks++;
         if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL frame_model got=%h exp=%h", obs_vec(), model_vec());
         end
         if (pixel_ce === 1'b1 && pixel_x == 0 && pixel_y == 0) begin
            if (seen) begin
               done = 1'b1;
               checks++;
               if (cnt != FRAME_CLK) begin
                  failures++;
                  $display("FAIL frame_period got=%0d exp=%0d", cnt, FRAME_CLK);
               end
            end
            seen = 1'b1;
            cnt = 0;
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL frame_period_timeout got seen=%0d exp two (0,0) presentations", seen);
      end
      $display("test_frame_period done");
   endtask

   task automatic test_line_wrap();
      bit found;
      wait_pix(H_TOTAL - 1, 10, found);
      tick();
      checks++;
      if (!found || pixel_x !== 10'd0 || pixel_y !== 10'd11) begin
         failures++;
         $display("FAIL line_wrap got found=%0d x=%0d y=%0d exp x=0 y=11", found, pixel_x, pixel_y);
      end
      wait_pix(H_TOTAL - 1, V_TOTAL - 1, found);
      tick();
      checks++;
      if (!found || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
         failures++;
         $display("FAIL frame_wrap got found=%0d x=%0d y=%0d exp x=0 y=0", found, pixel_x, pixel_y);
      end
      $display("test_line_wrap done");
   endtask

   task automatic test_decode();
      bit found;
      wait_pix(HS_START - 1, 0, found);
      checks++;
      if (!found || hsync_n !== 1'b1) begin
         failures++;
         $display("FAIL hs_before got found=%0d hsync_n=%b exp 1", found, hsync_n);
      end
      wait_pix(HS_START, 0, found);
      checks++;
      if (!found || hsync_n !== 1'b0) begin
         failures++;
         $display("FAIL hs_first got found=%0d hsync_n=%b exp 0", found, hsync_n);
      end
      wait_pix(HS_START + HS_LEN - 1, 0, found);
      checks++;
      if (!found || hsync_n !== 1'b0) begin
         failures++;
         $display("FAIL hs_last got found=%0d hsync_n=%b exp 0", found, hsync_n);
      end
      wait_pix(HS_START + HS_LEN, 0, found);
      checks++;
      if (!found || hsync_n !== 1'b1) begin
         failures++;
         $display("FAIL hs_after got found=%0d hsync_n=%b exp 1", found, hsync_n);
      end
      wait_pix(H_ACTIVE - 1, V_ACTIVE - 1, found);
      checks++;
      if (!found || active !== 1'b1) begin
         failures++;
         $display("FAIL active_corner got found=%0d active=%b exp 1", found, active);
      end
      wait_pix(H_ACTIVE, V_ACTIVE - 1, found);
      checks++;
      if (!found || active !== 1'b0) begin
         failures++;
         $display("FAIL active_right got found=%0d active=%b exp 0", found, active);
      end
      wait_pix(0, V_ACTIVE, found);
      checks++;
      if (!found || active !== 1'b0 || vsync_n !== 1'b1) begin
         failures++;
         $display("FAIL active_bottom got found=%0d active=%b vsync_n=%b exp 0,1", found, active, vsync_n);
      end
      wait_pix(0, VS_START, found);
      checks++;
      if (!found || vsync_n !== 1'b0) begin
         failures++;
         $display("FAIL vs_first got found=%0d vsync_n=%b exp 0", found, vsync_n);
      end
      wait_pix(H_TOTAL - 1, VS_START + VS_LEN - 1, found);
      checks++;
      if (!found || vsync_n !== 1'b0) begin
         failures++;
         $display("FAIL vs_last got found=%0d vsync_n=%b exp 0", found, vsync_n);
      end
      wait_pix(0, VS_START + VS_LEN, found);
      checks++;
      if (!found || vsync_n !== 1'b1) begin
         failures++;
         $display("FAIL vs_after got found=%0d vsync_n=%b exp 1", found, vsync_n);
      end
      for (int i = 0; i < FRAME_CLK; i++) begin
         tick();
         checks++;
         if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL decode_model got=%h exp=%h", obs_vec(), model_vec());
         end
      end
      $display("test_decode done");
   endtask

   task automatic test_enable_hold();
      bit found;
      logic [23:0] held;
      wait_pix(10, 5, found);
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL hold_reach got timeout exp pixel (10,5)");
      end
      held = obs_vec();
      enable = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (obs_vec() !== {1'b0, held[22:0]} || obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL enable_hold got=%h exp=%h", obs_vec(), {1'b0, held[22:0]});
         end
      end
      enable = 1'b1;
      tick();
      checks++;
      if (pixel_x !== 10'd11 || pixel_y !== 10'd5 || pixel_ce !== 1'b0) begin
         failures++;
         $display("FAIL resume_step got ce=%b x=%0d y=%0d exp ce=0 x=11 y=5", pixel_ce, pixel_x, pixel_y);
      end
      tick();
      checks++;
      if (pixel_x !== 10'd11 || pixel_ce !== 1'b1) begin
         failures++;
         $display("FAIL resume_ce got ce=%b x=%0d exp ce=1 x=11", pixel_ce, pixel_x);
      end
      $display("test_enable_hold done");
   endtask

   task automatic test_resync();
      bit found;
      logic [23:0] origin = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1};
      wait_pix(20, 12, found);
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL resync_reach got timeout exp pixel (20,12)");
      end
      resync = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs_vec() !== origin || obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL resync_hold got=%h exp=%h", obs_vec(), origin);
         end
      end
      resync = 1'b0;
      tick();
      checks++;
      if (pixel_ce !== 1'b1 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
         failures++;
         $display("FAIL resync_release got ce=%b x=%0d y=%0d exp ce=1 x=0 y=0", pixel_ce, pixel_x, pixel_y);
      end
      tick();
      checks++;
      if (pixel_ce !== 1'b0 || pixel_x !== 10'd1) begin
         failures++;
         $display("FAIL resync_next got ce=%b x=%0d exp ce=0 x=1", pixel_ce, pixel_x);
      end
      $display("test_resync done");
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(9) != 0);
         resync = ($urandom_range(199) == 0);
         tick();
         checks++;
         if (obs_vec() !== model_vec()) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs_vec(), model_vec());
         end
      end
      enable = 1'b1;
      resync = 1'b0;
      $display("test_random done");
   endtask

   task automatic test_async_reset();
      bit found;
      logic [23:0] rst_vec = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1};
      wait_pix(25, 10, found);
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL areset_reach got timeout exp pixel (25,10)");
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs_vec() !== rst_vec) begin
         failures++;
         $display("FAIL async_reset got=%h exp=%h", obs_vec(), rst_vec);
      end
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (pixel_ce !== 1'b1 || pixel_x !== 10'd0 || pixel_y !== 10'd0 || obs_vec() !== model_vec()) begin
         failures++;
         $display("FAIL areset_restart got=%h exp=%h", obs_vec(), model_vec());
      end
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_startup();
      test_frame_period();
      test_line_wrap();
      test_decode();
      test_enable_hold();
      test_resync();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pal_timing_gen.md
PAL_TIMING_GEN -- requirements
Module: pal_timing_gen

Interface
REQ-001 Parameter CE_DIV, default 2: clk cycles per pixel; must be at least 2.
REQ-002 Parameter H_TOTAL, default 864: pixels per line, at most 1024.
REQ-003 Parameter H_ACTIVE, default 720: active pixels per line.
REQ-004 Parameters HS_START, default 732, and HS_LEN, default 64: horizontal sync pixel window.
REQ-005 Parameter V_TOTAL, default 625: lines per frame, at most 1024.
REQ-006 Parameter V_ACTIVE, default 576: active lines per frame.
REQ-007 Parameters VS_START, default 581, and VS_LEN, default 5: vertical sync line window.
REQ-008 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-009 Port reset, input, 1: asynchronous, active-high reset.
REQ-010 Port enable, input, 1: run/hold control for the timing generator.
REQ-011 Port resync, input, 1: synchronous restart of the timing to pixel (0,0).
REQ-012 Port pixel_ce, output, 1: pixel clock enable, one clk wide.
REQ-013 Port pixel_x, output, 10: current pixel column, 0..H_TOTAL-1.
REQ-014 Port pixel_y, output, 10: current line, 0..V_TOTAL-1.
REQ-015 Port hsync_n, output, 1: active-low horizontal sync.
REQ-016 Port vsync_n, output, 1: active-low vertical sync.
REQ-017 Port active, output, 1: high inside the active picture.

Function
REQ-018 The divider counter div shall count 0..CE_DIV-1 and wrap to 0, advancing only while enable=1.
REQ-019 pixel_ce shall be registered and high for exactly one clk each time div reaches CE_DIV-1; it is low otherwise.
REQ-020 At the rising edge where pixel_ce=1, pixel_x shall increment; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
REQ-021 pixel_y shall wrap from V_TOTAL-1 to 0 on the same edge that pixel_x wraps, so the wrap (H_TOTAL-1, V_TOTAL-1) to (0,0) takes one edge.
REQ-022 hsync_n, vsync_n and active shall be registered and decoded from the next counter values, so they are always coincident with the presented pixel_x/pixel_y (zero relative latency).
REQ-023 hsync_n=0 iff HS_START <= pixel_x <= HS_START+HS_LEN-1.
REQ-024 vsync_n=0 iff VS_START <= pixel_y <= VS_START+VS_LEN-1.
REQ-025 active=1 iff pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-026 With CE_DIV=2 after reset release, edge 1 shall raise pixel_ce with (x,y)=(0,0), and edge 2 shall give x=1 with pixel_ce=0; pixel (0,0) is therefore presented with pixel_ce=1 exactly once per frame.
REQ-027 While enable=0: div, pixel_x, pixel_y and all sync outputs shall hold, and pixel_ce shall be 0 from the next edge.
REQ-028 When enable returns to 1, counting shall resume from the held div value with no skipped or duplicated pixel.
REQ-029 resync=1 at an edge shall force div=0, pixel_x=0, pixel_y=0 and pixel_ce=0, with syncs and active decoded for (0,0).
REQ-030 resync shall have priority over enable and over a coincident pixel_ce advance.
REQ-031 While resync is held high, the block shall stay at (0,0) with pixel_ce=0; after release it behaves as after reset.

Reset
REQ-032 Asserting reset shall immediately force div=0, pixel_ce=0, pixel_x=0, pixel_y=0, hsync_n=1, vsync_n=1, active=1.
REQ-033 Reset asserted mid-line or mid-frame shall discard all timing state; there is no partial-frame recovery.

Structure
REQ-034 The PAL default timing constants (864/720/732/64/625/576/581/5, CE_DIV=2) and the 10-bit coordinate width shall live in the shared package pal_timing_pkg.
REQ-035 The clock-enable divider shall be the sub-module pal_ce_div, with ports clk, reset, enable, clear and ce.

Verification
REQ-036 Reset, run CE_DIV=2: pixel_ce toggles 1,0,1,0; pixel_x 0,1,2 on successive pixel_ce edges; exactly 864*625*2 clk between (0,0) presentations.
REQ-037 Line wrap: at (863,10) pixel_ce edge -> next (0,11); at (863,624) -> next (0,0), one edge.
REQ-038 Decode: hsync_n=0 for pixel_x 732..795 only; vsync_n=0 for pixel_y 581..585 only; active=0 at (720,0) and (0,576), 1 at (719,575).
REQ-039 Drop enable for 7 clk at (100,5): outputs hold, pixel_ce=0 throughout; resume gives 101 with no gap.
REQ-040 Assert resync at (400,300) coincident with pixel_ce -> next edge (0,0), pixel_ce=0; (0,0) is presented once with pixel_ce=1 after release.
REQ-041 Assert reset asynchronously mid-clock at (500,200): outputs go to reset values before the next edge.
